// File: rtl/inst_line_responder_pkg.sv
// Shared definitions for the instruction-line responder: FSM encoding,
// line geometry defaults and a helper for the byte offset width of a line.
package inst_line_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam int DATA_W             = 32;
    localparam int WORD_BYTES_LOG2    = 2;
    localparam int WAIT_CNT_W         = 4;
    localparam int DEFAULT_LINE_WORDS = 16;
    localparam int LINE_OFFSET_WIDTH  = $clog2(DEFAULT_LINE_WORDS) + WORD_BYTES_LOG2;

    // Number of byte-address bits covered by one line of line_words words.
    function automatic int line_offset_width(input int line_words);
        return $clog2(line_words) + WORD_BYTES_LOG2;
    endfunction

endpackage

// File: rtl/inst_line_responder_ram.sv
// Backing word store: one synchronous write port, one asynchronous read port.
// Contents are deliberately untouched by reset.
module resp_word_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // A same-edge write is not yet visible here, so a load on that edge sees the old word.
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/inst_line_responder.sv
// Serves whole-line read bursts to an instruction cache from a preloadable word RAM.
// Handshakes: a transfer happens on a rising edge where valid && ready; data/valid/last hold while valid && !ready.
module inst_line_responder
    import inst_line_responder_pkg::*;
#(
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter int MEM_AW     = 10,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       m_araddr,
    input  logic              m_arvalid,
    output logic              m_arready,
    output logic [31:0]       m_rdata,
    output logic              m_rvalid,
    output logic              m_rlast,
    input  logic              m_rready,
    input  logic              wr_en,
    input  logic [MEM_AW-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    output logic [1:0]        dbg_state
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = line_offset_width(LINE_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
        (LATENCY > 0) ? WAIT_CNT_W'(LATENCY - 1) : '0;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_q, wait_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [MEM_AW-1:0]       base_q, base_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic                    rlast_q, rlast_d;

    logic [31:0]             line_byte_base;
    logic [MEM_AW-1:0]       req_base;
    logic [MEM_AW-1:0]       rd_addr;
    logic [DATA_W-1:0]       rd_word;
    logic                    unused_addr_bits;

    // Address bits above the memory window simply drop out: the window wraps.
    assign line_byte_base   = {m_araddr[31:OFF_W], OFF_W'(0)};
    assign req_base         = line_byte_base[MEM_AW+1:2];
    assign unused_addr_bits = ^{line_byte_base[31:MEM_AW+2], line_byte_base[1:0]};

    resp_word_ram #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    // Read address is the word the next load (if any) would fetch.
    always_comb begin
        rd_addr = base_q + MEM_AW'(beat_q) + MEM_AW'(1);
        case (state_q)
            IDLE:    rd_addr = req_base;
            WAIT:    rd_addr = base_q;
            default: rd_addr = base_q + MEM_AW'(beat_q) + MEM_AW'(1);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        beat_d   = beat_q;
        base_d   = base_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        case (state_q)
            IDLE: begin
                if (m_arvalid) begin
                    base_d = req_base;
                    beat_d = '0;
                    if (LATENCY == 0) begin
                        state_d  = BURST;
                        rdata_d  = rd_word;
                        rvalid_d = 1'b1;
                        rlast_d  = 1'b0;
                    end else begin
                        state_d = WAIT;
                        wait_d  = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    state_d  = BURST;
                    rdata_d  = rd_word;
                    rvalid_d = 1'b1;
                    rlast_d  = 1'b0;
                end else begin
                    wait_d = wait_q - WAIT_CNT_W'(1);
                end
            end
            BURST: begin
                if (m_rready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d  = IDLE;
                        beat_d   = '0;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end else begin
                        beat_d   = beat_q + BEAT_W'(1);
                        rdata_d  = rd_word;
                        rvalid_d = 1'b1;
                        rlast_d  = ((beat_q + BEAT_W'(1)) == LAST_BEAT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            beat_q   <= '0;
            base_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            beat_q   <= beat_d;
            base_q   <= base_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
        end
    end

    assign m_arready = (state_q == IDLE);
    assign m_rdata   = rdata_q;
    assign m_rvalid  = rvalid_q;
    assign m_rlast   = rlast_q;
    assign dbg_state = state_q;

endmodule
